// File: rtl/enc8to3_drain.sv
// enc8to3_drain: accepts a multi-hot byte and emits the index of each set bit,
// one per output handshake, highest-first or lowest-first.
module enc8to3_drain #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_vec,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [3:0] pend_cnt,
    output logic       zero_err
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t     state, state_n;
    logic [7:0] mask, mask_n;
    logic [2:0] pri;
    logic       accept, take;
    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mask     <= '0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_n;
            mask     <= mask_n;
            zero_err <= accept && (in_vec == 8'd0);
        end
    end
    always_comb begin
        state_n = state;
        mask_n  = mask;
        if (accept) begin
            mask_n  = in_vec;
            state_n = (in_vec != 8'd0) ? DRAIN : IDLE;
        end
        if (take) begin
            mask_n  = mask & ~(8'd1 << out_code);
            state_n = out_last ? IDLE : DRAIN;
        end
    end
    // Later matches overwrite earlier ones, so scan toward the winning end.
    always_comb begin
        pri = '0;
        for (int i = 0; i < 8; i++)
            if (mask[HIGH_FIRST ? i : 7 - i])
                pri = HIGH_FIRST ? 3'(i) : 3'(7 - i);
    end
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DRAIN);
        out_code  = out_valid ? pri : 3'd0;
        out_last  = out_valid && (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);
        pend_cnt  = 4'($countones(mask));
    end
endmodule

// File: tb/tb_enc8to3_drain.sv
// tb_enc8to3_drain: directed checks of both drain orders, sharing one stimulus.
module tb_enc8to3_drain;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_vec = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       h_in_ready, h_out_valid, h_out_last, h_zero_err;
    logic [2:0] h_out_code;
    logic [3:0] h_pend_cnt;
    logic       l_in_ready, l_out_valid, l_out_last, l_zero_err;
    logic [2:0] l_out_code;
    logic [3:0] l_pend_cnt;
    int vecs = 0;
    int errs = 0;

    enc8to3_drain #(.HIGH_FIRST(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(h_in_ready), .out_code(h_out_code), .out_valid(h_out_valid),
        .out_ready(out_ready), .out_last(h_out_last), .pend_cnt(h_pend_cnt),
        .zero_err(h_zero_err)
    );
    enc8to3_drain #(.HIGH_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(l_in_ready), .out_code(l_out_code), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .pend_cnt(l_pend_cnt),
        .zero_err(l_zero_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            vecs++;
            if ((h_in_ready && h_out_valid) || (h_out_valid && h_pend_cnt == 4'd0) ||
                (l_in_ready && l_out_valid) || (l_out_valid && l_pend_cnt == 4'd0)) begin
                errs++;
                $display("FAIL invariant t=%0t h rdy/vld/cnt=%b%b%0d l rdy/vld/cnt=%b%b%0d, required no overlap and cnt>0 when valid",
                         $time, h_in_ready, h_out_valid, h_pend_cnt, l_in_ready, l_out_valid, l_pend_cnt);
            end
        end
    end

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        in_vec = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        vecs++;
        if ({h_in_ready, h_out_valid, h_out_code, h_out_last, h_pend_cnt, l_in_ready, l_out_valid, l_out_code, l_out_last, l_pend_cnt}
            !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL %s idle h rdy=%b vld=%b code=%0d last=%b cnt=%0d l rdy=%b vld=%b code=%0d last=%b cnt=%0d, required rdy=1 vld=0 code=0 last=0 cnt=0",
                     name, h_in_ready, h_out_valid, h_out_code, h_out_last, h_pend_cnt,
                     l_in_ready, l_out_valid, l_out_code, l_out_last, l_pend_cnt);
        end
    endtask

    // hc holds the high-first code sequence, code i in hc[3*i +: 3]; low-first is its reverse.
    task automatic drain(input string name, input logic [7:0] v, input logic [23:0] hc, input int k);
        logic [7:0] acc_h, acc_l;
        logic [2:0] eh, el;
        acc_h = 8'd0;
        acc_l = 8'd0;
        out_ready = 1'b1;
        send(v);
        for (int i = 0; i < k; i++) begin
            eh = hc[3*i +: 3];
            el = hc[3*(k-1-i) +: 3];
            vecs++;
            if ({h_out_valid, h_out_code, h_out_last, h_pend_cnt} !== {1'b1, eh, i == k-1, 4'(k-i)}) begin
                errs++;
                $display("FAIL %s hi step %0d got vld=%b code=%0d last=%b cnt=%0d, required vld=1 code=%0d last=%b cnt=%0d",
                         name, i, h_out_valid, h_out_code, h_out_last, h_pend_cnt, eh, i == k-1, k-i);
            end
            vecs++;
            if ({l_out_valid, l_out_code, l_out_last, l_pend_cnt} !== {1'b1, el, i == k-1, 4'(k-i)}) begin
                errs++;
                $display("FAIL %s lo step %0d got vld=%b code=%0d last=%b cnt=%0d, required vld=1 code=%0d last=%b cnt=%0d",
                         name, i, l_out_valid, l_out_code, l_out_last, l_pend_cnt, el, i == k-1, k-i);
            end
            acc_h = acc_h | (8'd1 << h_out_code);
            acc_l = acc_l | (8'd1 << l_out_code);
            @(negedge clk);
        end
        check_idle(name);
        vecs++;
        if (acc_h !== v || acc_l !== v) begin
            errs++;
            $display("FAIL %s coverage got hi=%h lo=%h, required %h", name, acc_h, acc_l, v);
        end
    endtask

    task automatic test_reset();
        #12;
        check_idle("reset_held");
        vecs++;
        if (h_zero_err !== 1'b0 || l_zero_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_zero_err got %b%b, required 00", h_zero_err, l_zero_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_basic();
        drain("basic_a5", 8'hA5, {12'd0, 3'd0, 3'd2, 3'd5, 3'd7}, 4);
    endtask

    task automatic test_order();
        drain("order_81", 8'h81, {18'd0, 3'd0, 3'd7}, 2);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h0C);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({h_out_valid, h_out_code, h_out_last, h_pend_cnt, l_out_code} !== {1'b1, 3'd3, 1'b0, 4'd2, 3'd2}) begin
                errs++;
                $display("FAIL bp_hold %0d got vld=%b code=%0d last=%b cnt=%0d lo_code=%0d, required vld=1 code=3 last=0 cnt=2 lo_code=2",
                         i, h_out_valid, h_out_code, h_out_last, h_pend_cnt, l_out_code);
            end
            in_vec = 8'hFF;
            in_valid = (i != 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vecs++;
        if ({h_out_valid, h_out_code, h_out_last, h_pend_cnt} !== {1'b1, 3'd3, 1'b0, 4'd2}) begin
            errs++;
            $display("FAIL bp_first got vld=%b code=%0d last=%b cnt=%0d, required vld=1 code=3 last=0 cnt=2",
                     h_out_valid, h_out_code, h_out_last, h_pend_cnt);
        end
        @(negedge clk);
        vecs++;
        if ({h_out_valid, h_out_code, h_out_last, h_pend_cnt} !== {1'b1, 3'd2, 1'b1, 4'd1}) begin
            errs++;
            $display("FAIL bp_second got vld=%b code=%0d last=%b cnt=%0d, required vld=1 code=2 last=1 cnt=1",
                     h_out_valid, h_out_code, h_out_last, h_pend_cnt);
        end
        @(negedge clk);
        check_idle("bp_done");
    endtask

    task automatic test_zero();
        send(8'h00);
        vecs++;
        if ({h_zero_err, l_zero_err, h_out_valid, h_in_ready} !== 4'b1101) begin
            errs++;
            $display("FAIL zero_pulse got zerr=%b%b vld=%b rdy=%b, required zerr=11 vld=0 rdy=1",
                     h_zero_err, l_zero_err, h_out_valid, h_in_ready);
        end
        @(negedge clk);
        vecs++;
        if ({h_zero_err, l_zero_err, h_out_valid} !== 3'b000) begin
            errs++;
            $display("FAIL zero_end got zerr=%b%b vld=%b, required zerr=00 vld=0", h_zero_err, l_zero_err, h_out_valid);
        end
    endtask

    task automatic test_edges();
        drain("full_ff", 8'hFF, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8);
        drain("single_10", 8'h10, {21'd0, 3'd4}, 1);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'hF0);
        vecs++;
        if ({h_out_valid, h_out_code, h_pend_cnt} !== {1'b1, 3'd7, 4'd4}) begin
            errs++;
            $display("FAIL mid_first got vld=%b code=%0d cnt=%0d, required vld=1 code=7 cnt=4",
                     h_out_valid, h_out_code, h_pend_cnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("mid_after_reset");
        drain("after_reset_02", 8'h02, {21'd0, 3'd1}, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_backpressure();
        test_zero();
        test_edges();
        test_reset_mid();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/enc8to3_drain.md
Name: enc8to3_drain

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoders.
- Accepts one 8-bit multi-hot request vector over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one per output handshake, in priority order.
- Sits between request-collection logic and any consumer of binary indices, e.g. a decoder driving one-hot selects.

Parameters:
- HIGH_FIRST, 1, drain order: 1 = highest set index first (bit 7 down to bit 0); 0 = lowest set index first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vec  input  8  request vector; sampled on input handshake.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector; high exactly in IDLE.
- out_code  output  3  index of the current highest-priority pending bit.
- out_valid  output  1  out_code is valid; high exactly in DRAIN.
- out_ready  input  1  consumer accepts out_code.
- out_last  output  1  out_code is the final index of the current vector.
- pend_cnt  output  4  popcount of pending mask, 0..8.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- State: 8-bit pending mask; FSM with states IDLE and DRAIN.
- Reset (rst_n low, asynchronous):
  - mask = 0, state = IDLE, zero_err = 0.
  - Outputs during and after reset: in_ready = 1, out_valid = 0, out_code = 0, out_last = 0, pend_cnt = 0.
- IDLE:
  - in_ready = 1; out_valid = 0.
  - On in_valid && in_ready with in_vec != 0: mask <= in_vec; next state DRAIN.
  - On in_valid && in_ready with in_vec == 0: accept and discard; zero_err = 1 on the next cycle only; stay IDLE.
- DRAIN:
  - in_ready = 0; in_valid is ignored.
  - out_valid = 1.
  - out_code is combinational from mask: with HIGH_FIRST=1, the highest set index; with HIGH_FIRST=0, the lowest set index.
  - out_last = 1 when exactly one mask bit is set.
- Output handshake (out_valid && out_ready): clear mask[out_code].
  - If out_last: mask becomes 0; next state IDLE.
  - Otherwise stay in DRAIN.
- Backpressure: out_ready low holds mask; out_code and out_last stay stable while out_valid is high.
- Latency: first out_valid one cycle after input handshake. With out_ready held high, one index per cycle.
  - A vector with k set bits occupies DRAIN for exactly k cycles.
- Back-to-back vectors: after the final handshake the block returns to IDLE, so in_ready = 1 the next cycle. Minimum vector period = k+1 cycles.
- pend_cnt = popcount(mask), registered-state derived; counts down 1 per output handshake.
- Outside DRAIN: out_code = 0 and out_last = 0.
- Reset mid-DRAIN: pending indices are lost; no partial output follows. Block returns immediately to the reset state.
- Invariants (bench asserts):
  - in_ready and out_valid are never both high.
  - out_valid high implies mask != 0.
  - The OR of (1 << out_code) over all handshakes of a vector equals the accepted in_vec.

Test Plan:
- Reset: drive rst_n low mid-cycle -> in_ready=1, out_valid=0, pend_cnt=0 immediately, without waiting for a clock edge.
- Basic drain, HIGH_FIRST=1, in_vec=8'b1010_0101, out_ready=1 -> out_code 7,5,2,0 on four consecutive cycles; out_last only with 0; pend_cnt 4,3,2,1; then IDLE.
- Order, HIGH_FIRST=0, in_vec=8'h81 -> out_code 0 then 7; out_last with 7.
- Backpressure: in_vec=8'h0C, out_ready low for 3 cycles -> out_code=3 held stable with out_valid=1; then codes 3,2; in_valid pulses during DRAIN are ignored.
- Edges:
  - in_vec=8'h00 -> zero_err pulses one cycle; no out_valid.
  - in_vec=8'hFF -> 8 codes 7..0; pend_cnt starts at 8.
  - in_vec=8'h10 -> a single code 4 with out_last=1.
- Reset mid-operation: in_vec=8'hF0, assert rst_n after the first code -> mask cleared, out_valid=0; a new in_vec=8'h02 yields only code 1.
